// File: rtl/sr_latch_driver.sv
// -----------------------------------------------------------------------------
// sr_latch_driver
//
// Drives the S and R inputs of an external cross-coupled NOR SR latch. Each
// command accepted over a valid/ready handshake produces a dead-time phase, one
// clean S or R pulse, and a settle phase. Q/Qbar are then read back through
// 2-flop synchronizers, and the command is reported as good or bad.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   req_valid  command request
//   req_set    command type, 1 = set (Q->1), 0 = reset (Q->0); sampled on accept
//   req_ready  block can accept a command (registered)
//   S, R       latch drive, straight from flops
//   Q_fb       latch Q, asynchronous to clk
//   Qbar_fb    latch Qbar, asynchronous to clk
//   busy       command in progress
//   done       one-cycle completion strobe
//   err        sticky result of the last command (1 = latch did not follow)
//   q_sync     synchronized Q_fb
//
// Every output except busy and req_ready is a registered decode of the state
// the FSM was in during the previous cycle. The pins therefore lag the state
// register by one edge, which keeps S/R free of glitches. busy and req_ready
// change on the accept edge itself so that a second request is never taken.
// -----------------------------------------------------------------------------
module sr_latch_driver #(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic req_valid,
    input  logic req_set,
    output logic req_ready,
    output logic S,
    output logic R,
    input  logic Q_fb,
    input  logic Qbar_fb,
    output logic busy,
    output logic done,
    output logic err,
    output logic q_sync
);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        PULSE,
        SETTLE,
        CHECK
    } state_t;

    // Counter reload values; each phase exits on the cycle its counter is zero.
    localparam logic [CNT_W-1:0] PRE_LOAD    = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_CYCLES - 1);
    // Two extra settle cycles cover the synchronizer latency before CHECK.
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(GAP_CYCLES + 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             cmd;

    logic q_meta;
    logic qbar_meta;
    logic qbar_sync;

    // Synchronizer stage for the asynchronous latch feedback.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_meta    <= 1'b0;
            q_sync    <= 1'b0;
            qbar_meta <= 1'b0;
            qbar_sync <= 1'b0;
        end else begin
            q_meta    <= Q_fb;
            q_sync    <= q_meta;
            qbar_meta <= Qbar_fb;
            qbar_sync <= qbar_meta;
        end
    end

    // Command FSM and registered output stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cmd       <= 1'b0;
            S         <= 1'b0;
            R         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            req_ready <= 1'b0;
        end else begin
            // Pins follow the state held during the cycle that just ended.
            S    <= (state == PULSE) &&  cmd;
            R    <= (state == PULSE) && !cmd;
            done <= (state == CHECK);

            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    if (req_valid && req_ready) begin
                        cmd       <= req_set;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            state <= PULSE;
                            cnt   <= PULSE_LOAD;
                        end else begin
                            state <= PRE;
                            cnt   <= PRE_LOAD;
                        end
                    end
                end

                PRE: begin
                    if (cnt == '0) begin
                        state <= PULSE;
                        cnt   <= PULSE_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                PULSE: begin
                    if (cnt == '0) begin
                        state <= SETTLE;
                        cnt   <= SETTLE_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                SETTLE: begin
                    if (cnt == '0) begin
                        state <= CHECK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                CHECK: begin
                    // Wrong level, or Q == Qbar (both low after a forbidden
                    // or disturbed state), counts as a failed command.
                    err   <= (q_sync != cmd) || (qbar_sync == q_sync);
                    state <= IDLE;
                    cnt   <= '0;
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// -----------------------------------------------------------------------------
// tb_sr_latch_driver
//
// Two instances: index 0 uses the default timing (gap 2, pulse 4), index 1 uses
// gap 0, pulse 1. Each instance drives its own behavioural NOR latch. Q/Qbar of
// a latch can be overridden to emulate a stuck or disturbed latch. The expected
// waveforms come from the command timing rules: pulse window, done offset,
// ready offset, and the err outcome derived from the latch level seen at CHECK.
// -----------------------------------------------------------------------------
module tb_sr_latch_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst       = 2'b11;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_set   = 2'b00;
    logic [1:0] req_ready;
    logic [1:0] S_o;
    logic [1:0] R_o;
    logic [1:0] Q_fb;
    logic [1:0] Qbar_fb;
    logic [1:0] busy;
    logic [1:0] done;
    logic [1:0] err;
    logic [1:0] q_sync;

    // Latch override controls and the latch state itself.
    logic [1:0] fe    = 2'b00;
    logic [1:0] fq    = 2'b00;
    logic [1:0] fqb   = 2'b00;
    logic [1:0] q_lat = 2'b00;

    int n_tests = 0;
    int n_fail  = 0;
    bit last_err [2] = '{1'b0, 1'b0};

    sr_latch_driver #(.PULSE_CYCLES(4), .GAP_CYCLES(2), .CNT_W(8)) dut_a (
        .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_set(req_set[0]),
        .req_ready(req_ready[0]), .S(S_o[0]), .R(R_o[0]), .Q_fb(Q_fb[0]),
        .Qbar_fb(Qbar_fb[0]), .busy(busy[0]), .done(done[0]), .err(err[0]),
        .q_sync(q_sync[0])
    );

    sr_latch_driver #(.PULSE_CYCLES(1), .GAP_CYCLES(0), .CNT_W(8)) dut_b (
        .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_set(req_set[1]),
        .req_ready(req_ready[1]), .S(S_o[1]), .R(R_o[1]), .Q_fb(Q_fb[1]),
        .Qbar_fb(Qbar_fb[1]), .busy(busy[1]), .done(done[1]), .err(err[1]),
        .q_sync(q_sync[1])
    );

    // NOR latch: reacts within half a clock to the S/R drive.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (S_o[i])      q_lat[i] <= 1'b1;
            else if (R_o[i]) q_lat[i] <= 1'b0;
        end
    end

    always_comb begin
        Q_fb    = 2'b00;
        Qbar_fb = 2'b00;
        for (int i = 0; i < 2; i++) begin
            Q_fb[i]    = fe[i] ? fq[i]  : q_lat[i];
            Qbar_fb[i] = fe[i] ? fqb[i] : ~q_lat[i];
        end
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issues one command on instance sel and checks every cycle from accept to
    // the cycle req_ready returns. Entered and left at a falling edge.
    // fmode: 0 no override, 1 override from before accept, 2 override from the
    // last pulse cycle onward. hold keeps req_valid high; toggle flips req_set
    // every cycle.
    task automatic run_cmd(input int sel, input bit set, input int delay,
                           input int fmode, input bit fq_v, input bit fqb_v,
                           input bit hold, input bit toggle);
        int  g;
        int  p;
        int  d;
        int  waited;
        bit  cmd;
        bit  exp_q;
        bit  exp_qb;
        bit  exp_e;
        bit  in_pulse;
        string pfx;
        g = (sel == 1) ? 0 : 2;
        p = (sel == 1) ? 1 : 4;
        d = 2 * g + p + 3;
        if (!hold && delay > 0) begin
            req_valid[sel] = 1'b0;
            repeat (delay) @(negedge clk);
        end
        if (fmode == 1) begin
            fe[sel] = 1'b1; fq[sel] = fq_v; fqb[sel] = fqb_v;
        end
        req_valid[sel] = 1'b1;
        if (!toggle) req_set[sel] = set;
        waited = 0;
        while (!req_ready[sel] && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        pfx = $sformatf("d%0d", sel);
        chk_i({pfx, " accept_wait"}, waited, 0);
        chk({pfx, " err_hold_before_accept"}, err[sel], last_err[sel]);
        @(posedge clk);
        cmd = req_set[sel];
        if (fmode != 0) begin
            exp_q = fq_v; exp_qb = fqb_v;
        end else begin
            exp_q = cmd;  exp_qb = ~cmd;
        end
        exp_e = (exp_q != cmd) || (exp_q == exp_qb);
        #1;
        if (!hold) req_valid[sel] = 1'b0;
        if (toggle) req_set[sel] = ~req_set[sel];
        for (int k = 0; k <= d + 1; k++) begin
            if (fmode == 2 && k == g + p) begin
                fe[sel] = 1'b1; fq[sel] = fq_v; fqb[sel] = fqb_v;
            end
            @(negedge clk);
            in_pulse = (k >= g + 1) && (k <= g + p);
            pfx = $sformatf("d%0d k%0d", sel, k);
            chk({pfx, " S"}, S_o[sel], in_pulse && cmd);
            chk({pfx, " R"}, R_o[sel], in_pulse && !cmd);
            chk({pfx, " no_overlap"}, S_o[sel] & R_o[sel], 1'b0);
            chk({pfx, " done"}, done[sel], k == d);
            chk({pfx, " busy"}, busy[sel], k <= d);
            chk({pfx, " ready"}, req_ready[sel], k == d + 1);
            chk({pfx, " err"}, err[sel], (k >= d) ? exp_e : 1'b0);
            if (k == d) chk({pfx, " q_sync"}, q_sync[sel], exp_q);
            if (k < d + 1) begin
                @(posedge clk);
                #1;
                if (toggle) req_set[sel] = ~req_set[sel];
            end
        end
        fe[sel] = 1'b0;
        last_err[sel] = exp_e;
    endtask

    // Set command on instance 0 with reset applied on the second pulse edge.
    task automatic reset_mid_pulse();
        string pfx;
        req_valid[0] = 1'b1;
        req_set[0]   = 1'b1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            pfx = $sformatf("rst_mid k%0d", k);
            chk({pfx, " S"}, S_o[0], k == 3);
            if (k < 3) begin
                @(posedge clk);
                #1;
            end
        end
        rst[0] = 1'b1;
        @(negedge clk);
        chk("rst_mid S_drop", S_o[0], 1'b0);
        chk("rst_mid R", R_o[0], 1'b0);
        chk("rst_mid busy", busy[0], 1'b0);
        chk("rst_mid done", done[0], 1'b0);
        chk("rst_mid err", err[0], 1'b0);
        chk("rst_mid ready", req_ready[0], 1'b0);
        rst[0] = 1'b0;
        @(negedge clk);
        chk("rst_mid ready_after_release", req_ready[0], 1'b1);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("rst_mid no_done k%0d", k), done[0], 1'b0);
            chk($sformatf("rst_mid no_pulse k%0d", k), S_o[0] | R_o[0], 1'b0);
        end
        last_err[0] = 1'b0;
    endtask

    initial begin
        int  sel;
        int  fm;
        rst = 2'b11;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset d%0d S", i), S_o[i], 1'b0);
            chk($sformatf("reset d%0d R", i), R_o[i], 1'b0);
            chk($sformatf("reset d%0d busy", i), busy[i], 1'b0);
            chk($sformatf("reset d%0d done", i), done[i], 1'b0);
            chk($sformatf("reset d%0d err", i), err[i], 1'b0);
            chk($sformatf("reset d%0d ready", i), req_ready[i], 1'b0);
            chk($sformatf("reset d%0d q_sync", i), q_sync[i], 1'b0);
        end
        rst = 2'b00;
        @(negedge clk);
        chk("ready_after_reset d0", req_ready[0], 1'b1);
        chk("ready_after_reset d1", req_ready[1], 1'b1);

        // Plain set, then plain reset.
        run_cmd(0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cmd(0, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Latch stuck at Q=0/Qbar=1 during a set, then a good set.
        run_cmd(0, 1'b1, 1, 1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_cmd(0, 1'b1, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Both feedbacks low through settle/check on a reset command.
        run_cmd(0, 1'b0, 0, 2, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back requests with req_set toggling every cycle.
        req_set[0] = 1'b1;
        run_cmd(0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 3; n++)
            run_cmd(0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        req_valid[0] = 1'b0;
        @(negedge clk);

        // Reset in the middle of a pulse.
        reset_mid_pulse();

        // Minimal-timing instance.
        run_cmd(1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cmd(1, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized commands on both instances, some with disturbed feedback.
        for (int n = 0; n < 12; n++) begin
            sel = int'($urandom_range(0, 1));
            fm  = int'($urandom_range(0, 4));
            if (fm > 2) fm = 0;
            run_cmd(sel, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), fm,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "time limit");
    end

endmodule
